// File: rtl/mrmola_pkg.sv
// mrmola_pkg: shared widths and constants for the counter/blinker top
package mrmola_pkg;
    localparam int COUNT_W = 16;
    localparam int BLINK_BIT = 15;
    localparam logic [7:0] UIO_OE_ALL = 8'hFF;
endpackage

// File: rtl/blinker.sv
// blinker: registers one counter bit; no reset, defined after the first edge
module blinker
    import mrmola_pkg::*;
(
    input  logic               clk,
    input  logic [COUNT_W-1:0] currentCount,
    output logic               blink_wire
);
    logic blink_d, blink_q;
    logic unused_count;

    always_comb blink_d = currentCount[BLINK_BIT];

    always_ff @(posedge clk) blink_q <= blink_d;

    assign blink_wire = blink_q;
    assign unused_count = &{1'b0, currentCount};
endmodule

// File: rtl/counter.sv
// counter: free-running wrap-around up-counter, cleared asynchronously by rst_n
module counter
    import mrmola_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    output logic [COUNT_W-1:0] currentCount
);
    logic [COUNT_W-1:0] count_d, count_q;

    always_comb count_d = count_q + COUNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign currentCount = count_q;
endmodule

// File: rtl/tt_um_mrmola.sv
// tt_um_mrmola: Tiny Tapeout top exposing a 16-bit count and its registered blink bit
module tt_um_mrmola
    import mrmola_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [COUNT_W-1:0] current_count;
    logic               blink;
    logic               unused_in;

    counter u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .currentCount (current_count)
    );

    blinker u_blinker (
        .clk          (clk),
        .currentCount (current_count),
        .blink_wire   (blink)
    );

    assign uo_out    = {current_count[15:9], blink};
    assign uio_out   = current_count[7:0];
    assign uio_oe    = UIO_OE_ALL;
    // count bit 8 has no pin
    assign unused_in = &{1'b0, ena, ui_in, uio_in, current_count[8]};
endmodule

// File: tb/tb_tt_um_mrmola.sv
// tb_tt_um_mrmola: scoreboard bench for tt_um_mrmola plus standalone lockstep copies
module tb_tt_um_mrmola;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [7:0]  ui_in = 8'h5A;
    logic [7:0]  uio_in = 8'hA5;
    logic [7:0]  uo_out, uio_out, uio_oe;
    logic [15:0] sa_count;
    logic        sa_blink;

    typedef struct {
        string      name;
        logic [7:0] uio;
        logic [7:0] uo;
        logic [7:0] oe;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   checks = 0;
    int   failures = 0;
    bit   lock_en = 1'b0;

    tt_um_mrmola dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    counter u_sa_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .currentCount (sa_count)
    );

    blinker u_sa_blinker (
        .clk          (clk),
        .currentCount (sa_count),
        .blink_wire   (sa_blink)
    );

    always #5 clk = ~clk;

    task automatic expect_now(input string name, input logic [7:0] uio, input logic [7:0] uo);
        exp_t e;
        e.name = name;
        e.uio = uio;
        e.uo = uo;
        e.oe = 8'hFF;
        q.push_back(e);
        -> sample_ev;
        #1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        forever begin
            exp_t e;
            @(sample_ev);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (uio_out !== e.uio) begin
                    failures++;
                    $display("FAIL %s uio_out got=%02h want=%02h", e.name, uio_out, e.uio);
                end
                checks++;
                if (uo_out !== e.uo) begin
                    failures++;
                    $display("FAIL %s uo_out got=%02h want=%02h", e.name, uo_out, e.uo);
                end
                checks++;
                if (uio_oe !== e.oe) begin
                    failures++;
                    $display("FAIL %s uio_oe got=%02h want=%02h", e.name, uio_oe, e.oe);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (lock_en) begin
            checks++;
            if ({uo_out, uio_out} !== {sa_count[15:9], sa_blink, sa_count[7:0]}) begin
                failures++;
                $display("FAIL lockstep top=%02h_%02h standalone_count=%04h blink=%0b",
                         uo_out, uio_out, sa_count, sa_blink);
            end
        end
    end

    initial begin
        edges(5);
        lock_en = 1'b1;
        expect_now("reset", 8'h00, 8'h00);
        rst_n = 1'b1;
        edges(10);
        expect_now("count10", 8'd10, 8'h00);
        edges(32768 - 10);
        expect_now("count8000", 8'h00, 8'h80);
        edges(1);
        expect_now("count8001_blink", 8'h01, 8'h81);
        edges(65536 - 32769);
        expect_now("wrap0", 8'h00, 8'h01);
        edges(1);
        expect_now("wrap1", 8'h01, 8'h00);
        edges(16'h1234 - 1);
        expect_now("count1234", 8'h34, 8'h12);
        rst_n = 1'b0;
        #1;
        expect_now("async_clear", 8'h00, 8'h00);
        edges(1);
        expect_now("held_in_reset", 8'h00, 8'h00);
        rst_n = 1'b1;
        edges(3);
        expect_now("resume3", 8'h03, 8'h00);
        for (int i = 0; i < 10 && q.size() != 0; i++) #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
